// File: rtl/rk4_deadlock_watchdog.sv
// rk4_deadlock_watchdog
// Qualifies the registered `block` outputs of the RK4_LBE_B_32 HLS deadlock
// monitors into a confirmed deadlock. A trip needs THRESHOLD consecutive
// cycles in which any monitor reports blocked. On a trip the blocked monitors
// are latched, a sticky flag is set and a one-cycle interrupt is raised. Stall
// statistics are kept for status readback.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   block_in     per-monitor block flags (already registered)
//   enable       watchdog enable
//   clear        one-cycle clear of the sticky status
//   deadlock     sticky confirmed-deadlock flag
//   irq          one-cycle pulse on each trip
//   deadlock_src block_in snapshot taken at the trip
//   stall_cycles current run length of consecutive blocked cycles
//   max_stall    largest stall_cycles value since reset or clear
//   trip_count   saturating trip counter, cleared only by reset
module rk4_deadlock_watchdog #(
   parameter int NUM_MON   = 1,
   parameter int THRESHOLD = 1024,
   parameter int CNT_W     = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_MON-1:0] block_in,
   input  logic               enable,
   input  logic               clear,
   output logic               deadlock,
   output logic               irq,
   output logic [NUM_MON-1:0] deadlock_src,
   output logic [CNT_W-1:0]   stall_cycles,
   output logic [CNT_W-1:0]   max_stall,
   output logic [15:0]        trip_count
);

   typedef enum logic [1:0] {IDLE, WATCH, TRIPPED} state_t;

   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state;
   logic             any_blk;
   logic [CNT_W-1:0] stall_nx;
   logic             trip;

   assign any_blk = |block_in;

   // Next run length is needed both for the counter and for the running
   // maximum, so it is computed once here. clear and !enable both zero it.
   always_comb begin
      stall_nx = '0;
      trip     = 1'b0;
      if (!clear && enable) begin
         case (state)
            IDLE:    stall_nx = any_blk ? ONE : '0;
            WATCH: begin
               // stall_cycles < THRESHOLD here, so +1 cannot wrap
               if (any_blk) begin
                  stall_nx = stall_cycles + ONE;
                  trip     = (stall_nx == THR);
               end
            end
            TRIPPED: begin
               if (any_blk)
                  stall_nx = (stall_cycles == CNT_MAX) ? stall_cycles : stall_cycles + ONE;
            end
            default: stall_nx = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         deadlock     <= 1'b0;
         irq          <= 1'b0;
         deadlock_src <= '0;
         stall_cycles <= '0;
         max_stall    <= '0;
         trip_count   <= '0;
      end else begin
         irq          <= 1'b0;
         stall_cycles <= stall_nx;
         if (clear)
            max_stall <= '0;
         else if (stall_nx > max_stall)
            max_stall <= stall_nx;

         if (clear) begin
            // clear beats a coincident trip: no irq, no trip_count bump
            state        <= IDLE;
            deadlock     <= 1'b0;
            deadlock_src <= '0;
         end else if (!enable) begin
            // TRIPPED is sticky across disable; only WATCH is abandoned
            if (state == WATCH)
               state <= IDLE;
         end else begin
            case (state)
               IDLE: if (any_blk) state <= WATCH;
               WATCH: begin
                  if (!any_blk)
                     state <= IDLE;
                  else if (trip) begin
                     state        <= TRIPPED;
                     deadlock     <= 1'b1;
                     deadlock_src <= block_in;
                     irq          <= 1'b1;
                     if (trip_count != 16'hFFFF)
                        trip_count <= trip_count + 16'd1;
                  end
               end
               TRIPPED: state <= TRIPPED;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rk4_deadlock_watchdog.sv
// Directed bench for rk4_deadlock_watchdog with NUM_MON=2, THRESHOLD=8.
module tb_rk4_deadlock_watchdog;

   localparam int NM = 2;
   localparam int TH = 8;
   localparam int CW = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [NM-1:0] block_in;
   logic          enable;
   logic          clear;
   logic          deadlock;
   logic          irq;
   logic [NM-1:0] deadlock_src;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] max_stall;
   logic [15:0]   trip_count;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   rk4_deadlock_watchdog #(.NUM_MON(NM), .THRESHOLD(TH), .CNT_W(CW)) dut (
      .clock(clock), .reset_n(reset_n), .block_in(block_in), .enable(enable),
      .clear(clear), .deadlock(deadlock), .irq(irq), .deadlock_src(deadlock_src),
      .stall_cycles(stall_cycles), .max_stall(max_stall), .trip_count(trip_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // advance n rising edges, then sit 1ns past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".deadlock"}, 32'(deadlock), 0);
      chk({tag, ".irq"},      32'(irq), 0);
      chk({tag, ".src"},      32'(deadlock_src), 0);
      chk({tag, ".stall"},    stall_cycles, 0);
      chk({tag, ".max"},      max_stall, 0);
      chk({tag, ".trips"},    32'(trip_count), 0);
   endtask

   initial begin
      reset_n = 1'b0; block_in = '0; enable = 1'b1; clear = 1'b0;
      #1 chk_all_zero("rst");
      #21 reset_n = 1'b1;
      step(20);
      chk_all_zero("idle20");

      // nominal trip
      block_in = 2'b10;
      step(7);
      chk("nom.stall7", stall_cycles, 7);
      chk("nom.irq7", 32'(irq), 0);
      chk("nom.dl7", 32'(deadlock), 0);
      step(1);
      chk("nom.irq8", 32'(irq), 1);
      chk("nom.dl8", 32'(deadlock), 1);
      chk("nom.src", 32'(deadlock_src), 2);
      chk("nom.trips", 32'(trip_count), 1);
      step(1);
      chk("nom.irq9", 32'(irq), 0);
      step(1);
      chk("nom.stall10", stall_cycles, 10);
      chk("nom.max10", max_stall, 10);
      block_in = '0;
      step(1);
      chk("nom.stall_drop", stall_cycles, 0);
      chk("nom.dl_sticky", 32'(deadlock), 1);
      chk("nom.max_hold", max_stall, 10);
      clear = 1'b1; step(1); clear = 1'b0;
      chk("clr.dl", 32'(deadlock), 0);
      chk("clr.src", 32'(deadlock_src), 0);
      chk("clr.max", max_stall, 0);
      chk("clr.trips", 32'(trip_count), 1);

      // sub-threshold with one-cycle gap
      block_in = 2'b01;
      step(7);
      chk("sub.stall7", stall_cycles, 7);
      block_in = '0;
      step(1);
      chk("sub.gap", stall_cycles, 0);
      chk("sub.max", max_stall, 7);
      block_in = 2'b01;
      step(7);
      chk("sub.stall7b", stall_cycles, 7);
      chk("sub.nodl", 32'(deadlock), 0);
      chk("sub.trips", 32'(trip_count), 1);
      chk("sub.max7", max_stall, 7);
      step(1);
      chk("sub.trip_irq", 32'(irq), 1);
      chk("sub.trips2", 32'(trip_count), 2);

      // clear while blocked, then retrip
      clear = 1'b1; step(1); clear = 1'b0;
      chk("cb.dl", 32'(deadlock), 0);
      chk("cb.max", max_stall, 0);
      chk("cb.stall", stall_cycles, 0);
      step(7);
      chk("cb.stall7", stall_cycles, 7);
      chk("cb.irq7", 32'(irq), 0);
      step(1);
      chk("cb.irq8", 32'(irq), 1);
      chk("cb.trips3", 32'(trip_count), 3);

      // clear in the exact trip cycle
      clear = 1'b1; step(1); clear = 1'b0;
      step(7);
      chk("ct.stall7", stall_cycles, 7);
      clear = 1'b1; step(1); clear = 1'b0;
      chk("ct.irq", 32'(irq), 0);
      chk("ct.dl", 32'(deadlock), 0);
      chk("ct.trips", 32'(trip_count), 3);
      chk("ct.stall", stall_cycles, 0);

      // alternating monitors count as one run
      block_in = '0; step(1);
      for (int i = 0; i < 8; i++) begin
         block_in = i[0] ? 2'b10 : 2'b01;
         step(1);
      end
      chk("mix.irq", 32'(irq), 1);
      chk("mix.src", 32'(deadlock_src), 2);
      chk("mix.trips", 32'(trip_count), 4);
      block_in = '0; clear = 1'b1; step(1); clear = 1'b0;

      // enable gating
      enable = 1'b0; block_in = 2'b01;
      step(50);
      chk("en.stall", stall_cycles, 0);
      chk("en.dl", 32'(deadlock), 0);
      chk("en.trips", 32'(trip_count), 4);
      enable = 1'b1;
      step(7);
      chk("en.stall7", stall_cycles, 7);
      chk("en.irq7", 32'(irq), 0);
      step(1);
      chk("en.irq8", 32'(irq), 1);
      chk("en.trips5", 32'(trip_count), 5);
      // disable while tripped: stays tripped, counting stops and restarts
      enable = 1'b0; step(1);
      chk("ent.stall", stall_cycles, 0);
      chk("ent.dl", 32'(deadlock), 1);
      enable = 1'b1; step(1);
      chk("ent.stall1", stall_cycles, 1);
      chk("ent.irq", 32'(irq), 0);
      chk("ent.trips", 32'(trip_count), 5);
      block_in = '0; clear = 1'b1; step(1); clear = 1'b0;

      // async reset in the middle of a WATCH run
      block_in = 2'b01;
      step(5);
      chk("ar.stall5", stall_cycles, 5);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("ar");
      @(posedge clock); #1;
      reset_n = 1'b1; block_in = '0;
      step(1);
      chk("ar.idle", stall_cycles, 0);
      block_in = 2'b01;
      step(1);
      chk("ar.restart", stall_cycles, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
